// File: rtl/mmio_gpio_pkg.sv
// Shared offsets, ID constant and the byte-lane merge helper for the GPIO bank.
package mmio_gpio_pkg;

  localparam logic [9:0] OFF_OUT    = 10'h000;
  localparam logic [9:0] OFF_IN     = 10'h100;
  localparam logic [9:0] OFF_STAT   = 10'h180;
  localparam logic [9:0] OFF_MASK   = 10'h1C0;
  localparam logic [9:0] OFF_CYC_LO = 10'h300;
  localparam logic [9:0] OFF_CYC_HI = 10'h304;
  localparam logic [9:0] OFF_ID     = 10'h3F0;

  localparam logic [7:0] ID_MAGIC = 8'h47;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/mmio_gpio_bank_in_sync.sv
// One 32-bit input channel: 2-FF synchroniser followed by a previous-value
// register so a single-cycle rising-edge pulse can be derived.
module gpio_in_sync (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] async_in,
  output logic [31:0] sync,
  output logic [31:0] rise
);

  logic [31:0] meta_q, meta_d;
  logic [31:0] sync_q, sync_d;
  logic [31:0] prev_q, prev_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync = sync_q;
  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/mmio_gpio_bank.sv
// Memory-mapped GPIO bank: strobed OUT registers, synchronised IN ports with
// sticky edge status/mask/IRQ. Optional cycle counter: MMIO_GPIO_CYCLE_COUNTER_EN.
module mmio_gpio_bank
  import mmio_gpio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0012_0000,
  parameter int          NCH_OUT   = 2,
  parameter int          NCH_IN    = 1,
  parameter logic [31:0] OUT_RESET = 32'h0000_0000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CE,
  input  logic                  WE,
  input  logic [29:0]           MADDR,
  input  logic [31:0]           WDATA,
  input  logic [3:0]            WSTB,
  output logic [31:0]           RDATA,
  output logic                  HIT,
  output logic [NCH_OUT*32-1:0] GPIO_OUT,
  input  logic [NCH_IN*32-1:0]  GPIO_IN,
  output logic                  IRQ
);

  // Bus contract: CE qualifies the cycle; a write commits at this edge, a read
  // presents RDATA/HIT on the following cycle. No back-pressure, one access per cycle.
  logic       hit, wr, rd;
  logic [9:0] off;

  assign hit = CE && (MADDR[29:8] == BASE_ADDR[31:10]);
  assign wr  = hit && WE && (|WSTB);
  assign rd  = hit && !WE;
  assign off = {MADDR[7:0], 2'b00};

  logic       sel_out, sel_in, sel_stat, sel_mask, sel_id;
  logic [5:0] out_idx;
  logic [4:0] in_idx;
  logic [3:0] st_idx;

  assign sel_out  = (off[9:8] == OFF_OUT[9:8]);
  assign sel_in   = (off[9:7] == OFF_IN[9:7]);
  assign sel_stat = (off[9:6] == OFF_STAT[9:6]);
  assign sel_mask = (off[9:6] == OFF_MASK[9:6]);
  assign sel_id   = (off == OFF_ID);
  assign out_idx  = off[7:2];
  assign in_idx   = off[6:2];
  assign st_idx   = off[5:2];

  logic [31:0] out_q  [NCH_OUT];
  logic [31:0] out_d  [NCH_OUT];
  logic [31:0] stat_q [NCH_IN];
  logic [31:0] stat_d [NCH_IN];
  logic [31:0] mask_q [NCH_IN];
  logic [31:0] mask_d [NCH_IN];
  logic [31:0] sync_w [NCH_IN];
  logic [31:0] rise_w [NCH_IN];
  logic [31:0] rdata_q, rdata_d;
  logic        hit_q, hit_d;
  logic        irq_q, irq_d;
  logic [31:0] w1c;

  for (genvar j = 0; j < NCH_IN; j++) begin : g_in
    gpio_in_sync u_sync (
      .clk      (CLK),
      .rst      (RST),
      .async_in (GPIO_IN[j*32 +: 32]),
      .sync     (sync_w[j]),
      .rise     (rise_w[j])
    );
  end

  for (genvar i = 0; i < NCH_OUT; i++) begin : g_out
    assign GPIO_OUT[i*32 +: 32] = out_q[i];
  end

`ifdef MMIO_GPIO_CYCLE_COUNTER_EN
  logic        sel_cyc_lo, sel_cyc_hi;
  logic [63:0] cnt_q, cnt_d;
  logic [31:0] shadow_q, shadow_d;

  assign sel_cyc_lo = (off == OFF_CYC_LO);
  assign sel_cyc_hi = (off == OFF_CYC_HI);

  // Reading LO snapshots the high word so a LO-then-HI pair is coherent.
  always_comb begin
    cnt_d    = cnt_q + 64'd1;
    shadow_d = shadow_q;
    if (wr && sel_cyc_lo) begin
      cnt_d    = '0;
      shadow_d = '0;
    end else if (rd && sel_cyc_lo) begin
      shadow_d = cnt_q[63:32];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q    <= '0;
      shadow_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
    end
  end
`endif

  assign w1c = byte_merge(32'h0, WDATA, WSTB);

  always_comb begin
    for (int i = 0; i < NCH_OUT; i++) begin
      out_d[i] = out_q[i];
      if (wr && sel_out && (out_idx == 6'(i))) out_d[i] = byte_merge(out_q[i], WDATA, WSTB);
    end
    irq_d = 1'b0;
    for (int j = 0; j < NCH_IN; j++) begin
      mask_d[j] = mask_q[j];
      if (wr && sel_mask && (st_idx == 4'(j))) mask_d[j] = byte_merge(mask_q[j], WDATA, WSTB);
      // Rise is OR-ed in after the clear so a coincident edge survives W1C.
      stat_d[j] = stat_q[j];
      if (wr && sel_stat && (st_idx == 4'(j))) stat_d[j] = stat_q[j] & ~w1c;
      stat_d[j] = stat_d[j] | rise_w[j];
      irq_d = irq_d | (|(stat_q[j] & mask_q[j]));
    end
  end

  always_comb begin
    hit_d   = rd;
    rdata_d = '0;
    if (rd) begin
      if (sel_out) begin
        for (int i = 0; i < NCH_OUT; i++) begin
          if (out_idx == 6'(i)) rdata_d = out_q[i];
        end
      end
      for (int j = 0; j < NCH_IN; j++) begin
        if (sel_in && (in_idx == 5'(j)))   rdata_d = sync_w[j];
        if (sel_stat && (st_idx == 4'(j))) rdata_d = stat_q[j];
        if (sel_mask && (st_idx == 4'(j))) rdata_d = mask_q[j];
      end
      if (sel_id) rdata_d = {ID_MAGIC, 8'(NCH_OUT), 8'(NCH_IN), 8'h01};
`ifdef MMIO_GPIO_CYCLE_COUNTER_EN
      if (sel_cyc_lo) rdata_d = cnt_q[31:0];
      if (sel_cyc_hi) rdata_d = shadow_q;
`endif
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NCH_OUT; i++) out_q[i] <= OUT_RESET;
      for (int j = 0; j < NCH_IN; j++) begin
        stat_q[j] <= '0;
        mask_q[j] <= '0;
      end
      rdata_q <= '0;
      hit_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NCH_OUT; i++) out_q[i] <= out_d[i];
      for (int j = 0; j < NCH_IN; j++) begin
        stat_q[j] <= stat_d[j];
        mask_q[j] <= mask_d[j];
      end
      rdata_q <= rdata_d;
      hit_q   <= hit_d;
      irq_q   <= irq_d;
    end
  end

  assign RDATA = rdata_q;
  assign HIT   = hit_q;
  assign IRQ   = irq_q;

endmodule

// File: tb/tb_mmio_gpio_bank.sv
// Self-checking bench for mmio_gpio_bank (default parameters): reads are
// scoreboarded through exp_q, pin-level outputs are checked directly.
module tb_mmio_gpio_bank;

  localparam logic [31:0] BASE = 32'h0012_0000;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CE, WE;
  logic [29:0] MADDR;
  logic [31:0] WDATA;
  logic [3:0]  WSTB;
  logic [31:0] RDATA;
  logic        HIT;
  logic [63:0] GPIO_OUT;
  logic [31:0] GPIO_IN;
  logic        IRQ;

  int n_cmp = 0;
  int n_err = 0;

  logic [32:0] exp_q[$];
  logic        rd_launched;
  logic [32:0] e;
  logic [31:0] mdl_out [2];
  logic [31:0] mdl_mask;

  mmio_gpio_bank dut (
    .CLK      (CLK),
    .RST      (RST),
    .CE       (CE),
    .WE       (WE),
    .MADDR    (MADDR),
    .WDATA    (WDATA),
    .WSTB     (WSTB),
    .RDATA    (RDATA),
    .HIT      (HIT),
    .GPIO_OUT (GPIO_OUT),
    .GPIO_IN  (GPIO_IN),
    .IRQ      (IRQ)
  );

  // Clock and watchdog
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [29:0] waddr(input logic [31:0] off);
    logic [31:0] a;
    a = BASE + off;
    return a[31:2];
  endfunction

  function automatic logic [31:0] tb_merge(input logic [31:0] o, input logic [31:0] n,
                                           input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~m) | (n & m);
  endfunction

  // Driver tasks: each drives one bus cycle starting at a falling edge.
  task automatic bus_write(input logic [31:0] off, input logic [31:0] d, input logic [3:0] s);
    @(negedge CLK);
    CE = 1'b1; WE = 1'b1; MADDR = waddr(off); WDATA = d; WSTB = s;
  endtask

  task automatic bus_read(input logic [31:0] off, input logic exp_hit, input logic [31:0] exp_d);
    @(negedge CLK);
    CE = 1'b1; WE = 1'b0; MADDR = waddr(off); WDATA = '0; WSTB = '0;
    exp_q.push_back({exp_hit, exp_d});
  endtask

  task automatic bus_idle(input int n);
    @(negedge CLK);
    CE = 1'b0; WE = 1'b0; WSTB = '0;
    repeat (n) @(negedge CLK);
  endtask

  // Scoreboard: a read sampled at this edge is checked just after it.
  always @(posedge CLK) begin
    rd_launched = CE && !WE && !RST;
    #1;
    if (rd_launched) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rd_hit", 32'(HIT), 32'(e[32]));
        chk("rd_data", RDATA, e[31:0]);
      end
    end
  end

  initial begin
    int ch;
    logic [31:0] d, off;
    logic [3:0]  s;

    RST = 1'b1; CE = 1'b0; WE = 1'b0; MADDR = '0; WDATA = '0; WSTB = '0; GPIO_IN = '0;
    mdl_out[0] = '0; mdl_out[1] = '0; mdl_mask = '0;
    repeat (3) @(negedge CLK);
    chk("rst_out_lo", GPIO_OUT[31:0], 32'h0);
    chk("rst_out_hi", GPIO_OUT[63:32], 32'h0);
    chk("rst_rdata", RDATA, 32'h0);
    chk("rst_hit", 32'(HIT), 32'h0);
    chk("rst_irq", 32'(IRQ), 32'h0);
    RST = 1'b0;

    // Lane-strobed write, then read back the very next cycle
    bus_write(32'h004, 32'hDEAD_BEEF, 4'b0101);
    bus_read(32'h004, 1'b1, 32'h00AD_00EF);
    chk("out1_strobed", GPIO_OUT[63:32], 32'h00AD_00EF);
    chk("out0_untouched", GPIO_OUT[31:0], 32'h0);
    mdl_out[1] = 32'h00AD_00EF;

    // Random back-to-back write/read pairs on OUT[0..1] and MASK[0]
    for (int k = 0; k < 12; k++) begin
      ch  = $urandom_range(0, 2);
      d   = $urandom;
      s   = 4'($urandom_range(0, 15));
      off = (ch == 2) ? 32'h1C0 : 32'(ch * 4);
      bus_write(off, d, s);
      if (ch == 2) mdl_mask = tb_merge(mdl_mask, d, s);
      else         mdl_out[ch] = tb_merge(mdl_out[ch], d, s);
      bus_read(off, 1'b1, (ch == 2) ? mdl_mask : mdl_out[ch]);
    end
    chk("rand_out_lo", GPIO_OUT[31:0], mdl_out[0]);
    chk("rand_out_hi", GPIO_OUT[63:32], mdl_out[1]);

    // Map corners
    bus_read(32'h3F0, 1'b1, 32'h4702_0101);
    bus_read(32'h240, 1'b1, 32'h0);
    bus_read(32'h104, 1'b1, 32'h0);
    bus_read(32'h184, 1'b1, 32'h0);
    bus_read(32'h400, 1'b0, 32'h0);
    bus_read(32'hFFFF_FFFC, 1'b0, 32'h0);
    bus_write(32'h008, 32'h5555_5555, 4'hF);
    bus_read(32'h008, 1'b1, 32'h0);
    bus_write(32'h004, 32'h1234_5678, 4'h0);
    bus_read(32'h004, 1'b1, mdl_out[1]);
    chk("oor_write_lo", GPIO_OUT[31:0], mdl_out[0]);
    chk("oor_write_hi", GPIO_OUT[63:32], mdl_out[1]);
`ifndef MMIO_GPIO_CYCLE_COUNTER_EN
    bus_write(32'h300, 32'hFFFF_FFFF, 4'hF);
    bus_read(32'h300, 1'b1, 32'h0);
    bus_read(32'h304, 1'b1, 32'h0);
`else
    bus_write(32'h300, 32'h0, 4'h1);
    bus_read(32'h300, 1'b1, 32'h0);
    bus_read(32'h304, 1'b1, 32'h0);
`endif

    // Rising edge -> sticky status -> IRQ two cycles after the synchronised rise
    bus_write(32'h1C0, 32'h8, 4'hF);
    bus_idle(3);
    GPIO_IN = 32'h8;
    repeat (3) @(negedge CLK);
    chk("irq_early", 32'(IRQ), 32'h0);
    @(negedge CLK);
    chk("irq_rise", 32'(IRQ), 32'h1);
    bus_read(32'h180, 1'b1, 32'h8);
    bus_read(32'h100, 1'b1, 32'h8);
    bus_write(32'h180, 32'h8, 4'b1110);
    bus_read(32'h180, 1'b1, 32'h8);
    bus_write(32'h180, 32'h8, 4'hF);
    @(negedge CLK);
    CE = 1'b0;
    chk("irq_hold", 32'(IRQ), 32'h1);
    @(negedge CLK);
    chk("irq_clear", 32'(IRQ), 32'h0);
    bus_read(32'h180, 1'b1, 32'h0);

    // W1C landing on the same edge as a new rise: the set wins
    bus_idle(0);
    GPIO_IN = 32'h0;
    repeat (4) @(negedge CLK);
    GPIO_IN = 32'h8;
    @(negedge CLK);
    bus_write(32'h180, 32'h8, 4'hF);
    bus_read(32'h180, 1'b1, 32'h8);
    bus_idle(1);
    chk("irq_same_cycle", 32'(IRQ), 32'h1);

    // Asynchronous reset in the middle of a write
    bus_write(32'h000, 32'hFFFF_FFFF, 4'hF);
    bus_write(32'h004, 32'h1111_1111, 4'hF);
    #2 RST = 1'b1;
    #1;
    chk("arst_out_lo", GPIO_OUT[31:0], 32'h0);
    chk("arst_out_hi", GPIO_OUT[63:32], 32'h0);
    chk("arst_irq", 32'(IRQ), 32'h0);
    chk("arst_hit", 32'(HIT), 32'h0);
    chk("arst_rdata", RDATA, 32'h0);
    @(negedge CLK);
    CE = 1'b0; WE = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    repeat (4) @(negedge CLK);
    chk("post_rst_irq", 32'(IRQ), 32'h0);
    bus_read(32'h004, 1'b1, 32'h0);
    bus_read(32'h000, 1'b1, 32'h0);
    bus_read(32'h1C0, 1'b1, 32'h0);
    bus_read(32'h180, 1'b1, 32'h8);
    bus_idle(3);

    chk("sb_drain", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
